// File: rtl/pwm_timer_pkg.sv
// Shared types and reset constants for the PWM/period timer.
package pwm_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] PERIOD_RST = '1;
  localparam logic [31:0] DUTY_RST   = '0;

endpackage

// File: rtl/pwm_timer_if.sv
// Control/config/status bundle of the PWM timer; master drives, slave is the timer.
interface pwm_timer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             tick;
  logic             start;
  logic             stop;
  logic             oneshot;
  logic             cfg_wr;
  logic [WIDTH-1:0] period_in;
  logic [WIDTH-1:0] duty_in;
  logic [WIDTH-1:0] cnt;
  logic             pwm_out;
  logic             wrap;
  logic             busy;
  logic             cfg_pending;

  modport master (
    output tick, start, stop, oneshot, cfg_wr, period_in, duty_in,
    input  cnt, pwm_out, wrap, busy, cfg_pending
  );

  modport slave (
    input  tick, start, stop, oneshot, cfg_wr, period_in, duty_in,
    output cnt, pwm_out, wrap, busy, cfg_pending
  );

endinterface

// File: rtl/pwm_shadow_regs.sv
// Double-buffered period/duty: shadow captures writes, active updates in IDLE or on wrap.
module pwm_shadow_regs
  import pwm_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idle,
  input  logic             wrap_evt,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  output logic [WIDTH-1:0] period_act,
  output logic [WIDTH-1:0] duty_act,
  output logic [WIDTH-1:0] duty_nxt,
  output logic             cfg_pending
);

  logic [WIDTH-1:0] period_sh;
  logic [WIDTH-1:0] duty_sh;
  logic [WIDTH-1:0] period_nxt;
  logic             pend_nxt;

  // A write landing on the wrap edge still applies the old shadow; the new
  // values stay pending for the following wrap.
  always_comb begin
    period_nxt = period_act;
    duty_nxt   = duty_act;
    pend_nxt   = cfg_pending;
    if (idle && cfg_wr) begin
      period_nxt = period_in;
      duty_nxt   = duty_in;
      pend_nxt   = 1'b0;
    end else if (wrap_evt) begin
      period_nxt = period_sh;
      duty_nxt   = duty_sh;
      pend_nxt   = cfg_wr;
    end else if (cfg_wr) begin
      pend_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_sh   <= PERIOD_RST[WIDTH-1:0];
      duty_sh     <= DUTY_RST[WIDTH-1:0];
      period_act  <= PERIOD_RST[WIDTH-1:0];
      duty_act    <= DUTY_RST[WIDTH-1:0];
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_wr) begin
        period_sh <= period_in;
        duty_sh   <= duty_in;
      end
      period_act  <= period_nxt;
      duty_act    <= duty_nxt;
      cfg_pending <= pend_nxt;
    end
  end

endmodule

// File: rtl/pwm_timer.sv
// PWM/period timer: tick-enabled period counter with registered PWM, wrap pulse and status.
module pwm_timer
  import pwm_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  pwm_timer_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  logic             mode;
  logic             idle;
  logic             running;
  logic             busy_nxt;
  logic             wrap_evt;
  logic             wrap_q;
  logic             pwm_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] period_act;
  logic [WIDTH-1:0] duty_act;
  logic [WIDTH-1:0] duty_nxt;

  pwm_shadow_regs #(.WIDTH(WIDTH)) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .idle        (idle),
    .wrap_evt    (wrap_evt),
    .cfg_wr      (bus.cfg_wr),
    .period_in   (bus.period_in),
    .duty_in     (bus.duty_in),
    .period_act  (period_act),
    .duty_act    (duty_act),
    .duty_nxt    (duty_nxt),
    .cfg_pending (bus.cfg_pending)
  );

  assign wrap_evt = running && bus.tick && (cnt_q == period_act);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN: begin
        if (wrap_evt) begin
          if (mode || bus.stop) state_nxt = IDLE;
        end else if (bus.stop) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN:   if (wrap_evt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idle     = (state == IDLE);
    running  = !idle;
    busy_nxt = (state_nxt != IDLE);
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (idle)
      cnt_nxt = '0;
    else if (bus.tick)
      cnt_nxt = wrap_evt ? '0 : cnt_q + 1'b1;
  end

  // PWM is registered from next-cycle count and duty so it lines up with cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      pwm_q  <= 1'b0;
      mode   <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      wrap_q <= wrap_evt;
      pwm_q  <= busy_nxt && (cnt_nxt < duty_nxt);
      if (idle && bus.start) mode <= bus.oneshot;
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.pwm_out = pwm_q;
  assign bus.wrap    = wrap_q;
  assign bus.busy    = running;

endmodule

// File: tb/tb_pwm_timer.sv
// Scoreboard bench for pwm_timer: directed steps push expected outputs, monitor compares.
module tb_pwm_timer;

  typedef struct {
    logic [7:0] cnt;
    logic       pwm;
    logic       wrap;
    logic       busy;
    logic       pend;
    string      tag;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    errors = 0;
  string phase = "reset";
  exp_t  sb[$];

  pwm_timer_if #(.WIDTH(8)) bus ();

  pwm_timer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void compare(input exp_t e);
    checks++;
    if (bus.cnt !== e.cnt || bus.pwm_out !== e.pwm || bus.wrap !== e.wrap ||
        bus.busy !== e.busy || bus.cfg_pending !== e.pend) begin
      errors++;
      $display("FAIL %s: got cnt=%0d pwm=%b wrap=%b busy=%b pend=%b, expected cnt=%0d pwm=%b wrap=%b busy=%b pend=%b",
               e.tag, bus.cnt, bus.pwm_out, bus.wrap, bus.busy, bus.cfg_pending,
               e.cnt, e.pwm, e.wrap, e.busy, e.pend);
    end
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) compare(sb.pop_front());
  end

  task automatic step(input logic t, input logic s, input logic sp, input logic os,
                      input logic wr, input logic [7:0] p, input logic [7:0] d,
                      input logic [7:0] ec, input logic ep, input logic ew,
                      input logic eb, input logic epd);
    exp_t e;
    bus.tick = t; bus.start = s; bus.stop = sp; bus.oneshot = os;
    bus.cfg_wr = wr; bus.period_in = p; bus.duty_in = d;
    @(posedge clk);
    e.cnt = ec; e.pwm = ep; e.wrap = ew; e.busy = eb; e.pend = epd; e.tag = phase;
    sb.push_back(e);
    #1;
  endtask

  initial begin
    exp_t e;
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.oneshot = 0;
    bus.cfg_wr = 0; bus.period_in = 0; bus.duty_in = 0;
    @(posedge clk); #1;
    e.cnt = 0; e.pwm = 0; e.wrap = 0; e.busy = 0; e.pend = 0; e.tag = "in_reset";
    compare(e);
    @(posedge clk); #1;
    rst = 0;

    phase = "reset_idle";
    step(1,0,0,0,0,0,0, 0,0,0,0,0);
    phase = "cfg_idle_p4d2";
    step(0,0,0,0,1,4,2, 0,0,0,0,0);
    phase = "start_tick_ignored";
    step(1,1,0,0,0,0,0, 0,1,0,1,0);
    phase = "run_p4d2";
    for (int k = 1; k <= 10; k++) begin
      int c;
      c = k % 5;
      step(1,0,0,0,0,0,0, 8'(c), (c < 2), (c == 0), 1, 0);
    end

    phase = "cfg_mid_period";
    step(1,0,0,0,0,0,0, 1,1,0,1,0);
    step(1,0,0,0,1,9,5, 2,0,0,1,1);
    step(0,0,0,0,0,0,0, 2,0,0,1,1);
    step(1,0,0,0,0,0,0, 3,0,0,1,1);
    step(1,0,0,0,0,0,0, 4,0,0,1,1);
    step(1,0,0,0,0,0,0, 0,1,1,1,0);
    phase = "run_p9d5";
    for (int k = 1; k <= 9; k++) step(1,0,0,0,0,0,0, 8'(k), (k < 5), 0, 1, 0);

    phase = "cfg_at_wrap";
    step(1,0,0,0,1,2,1, 0,1,1,1,1);
    for (int k = 1; k <= 9; k++) step(1,0,0,0,0,0,0, 8'(k), (k < 5), 0, 1, 1);
    step(1,0,0,0,0,0,0, 0,1,1,1,0);
    phase = "run_p2d1";
    step(1,0,0,0,0,0,0, 1,0,0,1,0);
    step(1,0,0,0,0,0,0, 2,0,0,1,0);
    phase = "stop_at_wrap";
    step(1,0,1,0,0,0,0, 0,0,1,0,0);
    step(1,0,0,0,0,0,0, 0,0,0,0,0);

    phase = "oneshot";
    step(0,0,0,0,1,3,2, 0,0,0,0,0);
    step(0,1,0,1,0,0,0, 0,1,0,1,0);
    for (int k = 1; k <= 4; k++) begin
      step(0,0,0,0,0,0,0, 8'(k - 1), ((k - 1) < 2), 0, 1, 0);
      step(1,0,0,0,0,0,0, 8'(k % 4), (k < 2), (k == 4), (k < 4), 0);
    end
    step(0,0,0,0,0,0,0, 0,0,0,0,0);
    step(1,0,0,0,0,0,0, 0,0,0,0,0);

    phase = "drain";
    step(0,0,0,0,1,4,2, 0,0,0,0,0);
    step(0,1,0,0,0,0,0, 0,1,0,1,0);
    step(1,0,0,0,0,0,0, 1,1,0,1,0);
    step(1,0,1,0,0,0,0, 2,0,0,1,0);
    step(1,0,1,0,0,0,0, 3,0,0,1,0);
    step(1,1,0,0,0,0,0, 4,0,0,1,0);
    step(1,0,0,0,0,0,0, 0,0,1,0,0);
    step(1,0,0,0,0,0,0, 0,0,0,0,0);

    phase = "duty0_startstop";
    step(0,0,0,0,1,2,0, 0,0,0,0,0);
    step(0,1,1,0,0,0,0, 0,0,0,1,0);
    step(1,0,0,0,0,0,0, 1,0,0,1,0);
    step(1,0,0,0,0,0,0, 2,0,0,1,0);
    step(1,0,0,0,0,0,0, 0,0,1,1,0);
    step(1,0,0,0,0,0,0, 1,0,0,1,0);
    step(1,0,1,0,0,0,0, 2,0,0,1,0);
    step(1,0,0,0,0,0,0, 0,0,1,0,0);

    phase = "duty_gt_period";
    step(0,0,0,0,1,2,3, 0,0,0,0,0);
    step(0,1,0,0,0,0,0, 0,1,0,1,0);
    step(1,0,0,0,0,0,0, 1,1,0,1,0);
    step(1,0,0,0,0,0,0, 2,1,0,1,0);
    step(1,0,0,0,0,0,0, 0,1,1,1,0);
    step(1,0,0,0,0,0,0, 1,1,0,1,0);
    step(1,0,1,0,0,0,0, 2,1,0,1,0);
    step(1,0,0,0,0,0,0, 0,0,1,0,0);

    phase = "pre_reset";
    step(0,0,0,0,1,5,4, 0,0,0,0,0);
    step(0,1,0,0,0,0,0, 0,1,0,1,0);
    step(1,0,0,0,0,0,0, 1,1,0,1,0);
    step(1,0,0,0,1,1,1, 2,1,0,1,1);
    step(1,0,0,0,0,0,0, 3,1,0,1,1);

    @(negedge clk); #1;
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.cfg_wr = 0;
    rst = 1;
    #1;
    e.cnt = 0; e.pwm = 0; e.wrap = 0; e.busy = 0; e.pend = 0; e.tag = "async_reset";
    compare(e);
    @(posedge clk); #1;
    rst = 0;

    phase = "post_reset_idle";
    step(1,0,0,0,0,0,0, 0,0,0,0,0);
    step(1,0,0,0,0,0,0, 0,0,0,0,0);
    phase = "post_reset_defaults";
    step(0,1,0,0,0,0,0, 0,0,0,1,0);
    for (int k = 1; k <= 255; k++) step(1,0,0,0,0,0,0, 8'(k), 0, 0, 1, 0);
    step(1,0,0,0,0,0,0, 0,0,1,1,0);
    step(1,0,1,0,0,0,0, 1,0,0,1,0);
    step(0,0,0,0,0,0,0, 1,0,0,1,0);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_timer.md
Name: pwm_timer

Overview:
Programmable PWM/period timer that sits directly downstream of the team's up-counter/prescaler stage. It consumes that stage's one-cycle terminal-count pulse as a count-enable `tick`. It runs an internal period counter and produces a PWM waveform, a wrap event and status flags. Period and duty are double-buffered through shadow registers, so software updates never tear a PWM cycle.

Parameters:
WIDTH, 8, width of the counter, period and duty values

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  count enable, one-cycle pulse from upstream prescaler counter
start  in  1  start request; honoured only in IDLE
stop  in  1  graceful stop request; finish current period, then IDLE
oneshot  in  1  mode select, sampled on an accepted start (1 = single period)
cfg_wr  in  1  write strobe for period_in/duty_in into shadow registers
period_in  in  WIDTH  period value P; one PWM cycle = P+1 ticks
duty_in  in  WIDTH  duty value D; pwm high for D ticks of each cycle
cnt  out  WIDTH  current count
pwm_out  out  1  registered PWM output
wrap  out  1  one-cycle pulse on the edge where cnt goes P -> 0
busy  out  1  high in RUN or DRAIN
cfg_pending  out  1  shadow holds values not yet applied

Behaviour:
- Reset values:
  - cnt=0, pwm_out=0, wrap=0, busy=0, cfg_pending=0.
  - period_act and period_shadow = all ones; duty_act and duty_shadow = 0.
  - State = IDLE; mode flop = 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start. cnt<=0, mode<=oneshot. A tick in the start cycle is ignored.
  - RUN -> DRAIN on stop when there is no wrap in the same cycle.
  - RUN -> IDLE at wrap if mode=1, or if stop coincides with wrap.
  - DRAIN -> IDLE at wrap.
  - start is ignored in RUN/DRAIN. stop is ignored in IDLE/DRAIN. start+stop together in IDLE: start wins.
- Counting (RUN/DRAIN only, on tick):
  - If cnt==period_act: cnt<=0, wrap<=1. Otherwise cnt<=cnt+1.
  - No tick: cnt holds.
  - In IDLE, cnt is forced to 0.
  - wrap is 0 in every cycle where it is not asserted.
- P=0: every tick wraps, so wrap follows tick with 1-cycle latency.
- Shadow registers:
  - cfg_wr captures period_in/duty_in into the shadow on the same edge.
  - In IDLE, the active registers are also loaded on that edge, and cfg_pending stays 0.
  - In RUN/DRAIN, cfg_wr sets cfg_pending. The shadow is copied to active on the wrap edge, and cfg_pending clears.
  - cfg_wr coincident with wrap: the old shadow goes to active, the new values go to shadow, and cfg_pending=1.
  - A second cfg_wr before wrap overwrites the shadow (last write wins).
- pwm_out:
  - A flop whose value in every cycle equals busy && (cnt < duty_act), computed from next-state values so there is zero lag vs cnt.
  - D=0 gives constant low. D>P gives constant high while busy.
  - pwm_out is 0 in IDLE.
- Arithmetic: unsigned WIDTH-bit. cnt never exceeds period_act, so there is no natural overflow path.
- Reset mid-operation: all state returns to reset values asynchronously, and the shadow contents are lost.

Decomposition:
- Package pwm_timer_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - reset constants (PERIOD_RST = all ones, DUTY_RST = 0).
- One natural sub-module, pwm_shadow_regs: shadow/active register pair with pending flag, and apply-on-wrap/apply-in-idle logic.
- The FSM, counter and compare stay in the top level.

Test Plan:
- Reset, then cfg_wr P=4 D=2 in IDLE, start, tick every cycle -> cnt 0,1,2,3,4,0…; pwm_out 1,1,0,0,0 repeating; wrap pulses every 5 ticks; cfg_pending stays 0.
- Running with P=4 D=2, cfg_wr P=9 D=5 mid-period -> cfg_pending=1 until wrap; from the next cycle cnt counts to 9 with 5-high duty; cfg_pending=0.
- oneshot=1 start, P=3, tick every 2nd cycle -> exactly one wrap after 4 ticks, then busy=0, cnt=0, pwm_out=0.
- stop at cnt=1 with P=4 -> state DRAIN, counting continues to 4, wrap, then IDLE. A repeated stop and start in DRAIN are ignored.
- Boundaries: D=0 gives pwm_out constantly 0. D=P+1 gives pwm_out constantly 1 while busy. stop coincident with wrap gives IDLE on that edge. cfg_wr coincident with wrap gives old shadow applied and cfg_pending=1.
- Assert rst mid-RUN at cnt=3 -> all outputs 0 immediately; period_act=all ones, duty_act=0. After release, state stays IDLE until start.
